// File: rtl/counter_multi_ch.sv
// NCH-channel start/halt counter bank with per-channel limit, saturate/wrap mode and limit flag.
// Optional shared prescaler enabled by defining CR_PRESCALE_EN.
module counter_multi_ch #(
    parameter int               NCH     = 4,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_RST = {WIDTH{1'b1}},
    parameter int               PRESC   = 10,
    parameter int               SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 CR_CLK,
    input  logic                 CR_RST_N,
    input  logic [NCH-1:0]       CR_CLR,
    input  logic [NCH-1:0]       CR_EN,
    input  logic [NCH-1:0]       CR_HALT,
    input  logic [NCH-1:0]       CR_MODE,
    input  logic                 CR_LOADMAX,
    input  logic [SELW-1:0]      CR_LDSEL,
    input  logic [WIDTH-1:0]     D_MAX,
    output logic [NCH*WIDTH-1:0] CR_DOUT,
    output logic [NCH-1:0]       CR_COF,
    output logic [NCH-1:0]       CR_RUN
);

    if (NCH < 1 || NCH > 16 || WIDTH < 2 || WIDTH > 32 || PRESC < 1) begin : g_param_check
        $error("counter_multi_ch: parameter out of range");
    end

    logic [WIDTH-1:0] dout_q [NCH];
    logic [WIDTH-1:0] dout_d [NCH];
    logic [WIDTH-1:0] lim_q  [NCH];
    logic [WIDTH-1:0] lim_d  [NCH];
    logic [NCH-1:0]   cof_q, cof_d;
    logic [NCH-1:0]   run_q, run_d;
    logic             tick;

    // One count event: returns {limit flag, next count}; at/above the limit saturate or wrap.
    function automatic logic [WIDTH:0] count_step(input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] lim,
                                                  input logic             wrap);
        logic [WIDTH:0] res;
        if (cur >= lim) begin
            res = {1'b1, (wrap ? {WIDTH{1'b0}} : cur)};
        end else begin
            res = {1'b0, cur + 1'b1};
        end
        return res;
    endfunction

`ifdef CR_PRESCALE_EN
    localparam int            PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick    = (presc_q == PLAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge CR_CLK or negedge CR_RST_N) begin
        if (!CR_RST_N) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        cof_d = cof_q;
        run_d = run_q;
        for (int i = 0; i < NCH; i++) begin
            dout_d[i] = dout_q[i];
            lim_d[i]  = (CR_LOADMAX && (int'(CR_LDSEL) == i)) ? D_MAX : lim_q[i];
            if (CR_CLR[i]) begin
                dout_d[i] = '0;
                cof_d[i]  = 1'b0;
                run_d[i]  = 1'b0;
            end else begin
                // HALT beats EN; EN counts on the very edge it is sampled.
                run_d[i] = (run_q[i] | CR_EN[i]) & ~CR_HALT[i];
                if (run_d[i] && tick) begin
                    {cof_d[i], dout_d[i]} = count_step(dout_q[i], lim_q[i], CR_MODE[i]);
                end
            end
        end
    end

    always_ff @(posedge CR_CLK or negedge CR_RST_N) begin
        if (!CR_RST_N) begin
            for (int i = 0; i < NCH; i++) begin
                dout_q[i] <= '0;
                lim_q[i]  <= MAX_RST;
            end
            cof_q <= '0;
            run_q <= '0;
        end else begin
            dout_q <= dout_d;
            lim_q  <= lim_d;
            cof_q  <= cof_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        CR_DOUT = '0;
        for (int i = 0; i < NCH; i++) begin
            CR_DOUT[i*WIDTH +: WIDTH] = dout_q[i];
        end
    end

    assign CR_COF = cof_q;
    assign CR_RUN = run_q;

endmodule

// File: tb/tb_counter_multi_ch.sv
// Directed self-checking bench for counter_multi_ch (5 channels, 8-bit, reset limit 12).
module tb_counter_multi_ch;

    localparam int NCH  = 5;
    localparam int W    = 8;
    localparam int SELW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   clr, en, halt, mode;
    logic             loadmax;
    logic [SELW-1:0]  ldsel;
    logic [W-1:0]     dmax;
    logic [NCH*W-1:0] dout;
    logic [NCH-1:0]   cof, run;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_multi_ch #(
        .NCH(NCH), .WIDTH(W), .MAX_RST(8'd12), .PRESC(4), .SELW(SELW)
    ) dut (
        .CR_CLK(clk), .CR_RST_N(rst_n), .CR_CLR(clr), .CR_EN(en), .CR_HALT(halt),
        .CR_MODE(mode), .CR_LOADMAX(loadmax), .CR_LDSEL(ldsel), .D_MAX(dmax),
        .CR_DOUT(dout), .CR_COF(cof), .CR_RUN(run)
    );

    function automatic logic [W-1:0] dv(input int ch);
        return W'(dout >> (ch * W));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int val);
        loadmax = 1'b1;
        ldsel   = SELW'(ch);
        dmax    = W'(val);
        step(1);
        loadmax = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; clr = '0; en = '0; halt = '0; mode = '0;
        loadmax = 1'b0; ldsel = '0; dmax = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_dout", dout, '0);
        check("rst_cof", cof, '0);
        check("rst_run", run, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifndef CR_PRESCALE_EN
        // Ch0 saturate, limit 5
        load(0, 5);
        en[0] = 1'b1; step(1); en[0] = 1'b0;
        check("sat_d1", dv(0), 1);
        check("sat_run", run[0], 1'b1);
        check("sat_cof1", cof[0], 1'b0);
        for (int k = 2; k <= 5; k++) begin
            step(1);
            check("sat_cnt", dv(0), k);
            check("sat_cof_lo", cof[0], 1'b0);
        end
        step(1);
        check("sat_hold", dv(0), 5);
        check("sat_cof_hi", cof[0], 1'b1);
        step(1);
        check("sat_hold2", dv(0), 5);
        check("sat_cof_lvl", cof[0], 1'b1);
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        check("clr_d", dv(0), 0);
        check("clr_cof", cof[0], 1'b0);
        check("clr_run", run[0], 1'b0);

        // Ch1 wrap, limit 3
        load(1, 3);
        mode[1] = 1'b1;
        en[1] = 1'b1; step(1); en[1] = 1'b0;
        check("wrap_d1", dv(1), 1);
        step(1); check("wrap_d2", dv(1), 2); check("wrap_c2", cof[1], 1'b0);
        step(1); check("wrap_d3", dv(1), 3); check("wrap_c3", cof[1], 1'b0);
        step(1); check("wrap_d0", dv(1), 0); check("wrap_c0", cof[1], 1'b1);
        step(1); check("wrap_d1b", dv(1), 1); check("wrap_c1b", cof[1], 1'b0);
        step(2); check("wrap_d3b", dv(1), 3);
        step(1); check("wrap_d0b", dv(1), 0); check("wrap_c0b", cof[1], 1'b1);
        clr[1] = 1'b1; step(1); clr[1] = 1'b0;

        // Ch2 halt with simultaneous enable, resume, clear with enable
        en[2] = 1'b1; step(1); en[2] = 1'b0;
        step(6);
        check("halt_pre", dv(2), 7);
        halt[2] = 1'b1; en[2] = 1'b1; step(1); halt[2] = 1'b0; en[2] = 1'b0;
        check("halt_d", dv(2), 7);
        check("halt_run", run[2], 1'b0);
        step(1);
        check("halt_idle", dv(2), 7);
        en[2] = 1'b1; step(1); en[2] = 1'b0;
        check("resume_d", dv(2), 8);
        check("resume_run", run[2], 1'b1);
        clr[2] = 1'b1; en[2] = 1'b1; step(1); clr[2] = 1'b0; en[2] = 1'b0;
        check("clren_d", dv(2), 0);
        check("clren_run", run[2], 1'b0);
        step(1);
        check("clren_idle", dv(2), 0);

        // Ch3: lower limit below current count
        en[3] = 1'b1; step(1); en[3] = 1'b0;
        step(3);
        check("low_pre", dv(3), 4);
        halt[3] = 1'b1; loadmax = 1'b1; ldsel = 3'd3; dmax = 8'd2;
        step(1);
        halt[3] = 1'b0; loadmax = 1'b0;
        check("low_halt", dv(3), 4);
        en[3] = 1'b1; step(1); en[3] = 1'b0;
        check("low_d", dv(3), 4);
        check("low_cof", cof[3], 1'b1);
        check("low_run", run[3], 1'b1);
        step(1);
        check("low_d2", dv(3), 4);

        // Out-of-range select must not touch any limit
        load(5, 100);
        clr[3] = 1'b1; step(1); clr[3] = 1'b0;
        en[3] = 1'b1; step(1); en[3] = 1'b0;
        step(2);
        check("badsel_ch3", dv(3), 2);
        check("badsel_c3", cof[3], 1'b1);
        en[4] = 1'b1; step(1); en[4] = 1'b0;
        step(11);
        check("rstlim_d", dv(4), 12);
        check("rstlim_c0", cof[4], 1'b0);
        step(1);
        check("rstlim_hold", dv(4), 12);
        check("rstlim_c1", cof[4], 1'b1);
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
`endif

        // Ch0 limit 10, run 40 clocks
        load(0, 10);
        en[0] = 1'b1; step(1); en[0] = 1'b0;
        step(19);
`ifdef CR_PRESCALE_EN
        check("run20_d", dv(0), 5);
        check("run20_c", cof[0], 1'b0);
`else
        check("run20_d", dv(0), 10);
        check("run20_c", cof[0], 1'b1);
`endif
        step(20);
        check("run40_d", dv(0), 10);
`ifdef CR_PRESCALE_EN
        check("run40_c", cof[0], 1'b0);
`else
        check("run40_c", cof[0], 1'b1);
`endif
        check("run40_run", run[0], 1'b1);

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 1'b0;
        #1;
        check("arst_dout", dout, '0);
        check("arst_cof", cof, '0);
        check("arst_run", run, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

`ifndef CR_PRESCALE_EN
        en[0] = 1'b1; step(1); en[0] = 1'b0;
        step(12);
        check("arst_lim_d", dv(0), 12);
        check("arst_lim_c", cof[0], 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
